commit_cfi_marker_checker: RTL and testbench

Parametrised control-flow-integrity checker on the Ariane commit stage. It watches all `NR_COMMIT_PORTS` commit ports in program order and requires every committed call to be followed immediately by a call marker NOP, and every committed return by a return marker NOP. Compared with the fixed two-port checker it adds:
- N-port in-order scanning;
- a count-only mode;
- saturating per-kind violation counters;
- precise `tval` reporting.

Its exception output feeds the commit stage's exception path.

---
 rtl/commit_cfi_marker_checker_if.sv | 31 +++
 rtl/commit_cfi_marker_checker.sv | 167 ++++++++++++++++
 tb/tb_commit_cfi_marker_checker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_cfi_marker_checker_if.sv
// Commit-port bundle seen by the CFI marker checker: per-port commit fields in,
// registered violation exception out.
interface commit_cfi_marker_checker_if #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = 64
);
    logic [NR_COMMIT_PORTS-1:0]           commit_ack_i;
    logic [NR_COMMIT_PORTS-1:0][3:0]      commit_fu_i;
    logic [NR_COMMIT_PORTS-1:0][7:0]      commit_op_i;
    logic [NR_COMMIT_PORTS-1:0][5:0]      commit_rd_i;
    logic [NR_COMMIT_PORTS-1:0][5:0]      commit_rs1_i;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_result_i;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_pc_i;
    logic [NR_COMMIT_PORTS-1:0]           commit_ex_valid_i;

    logic                                 exception_valid_o;
    logic [XLEN-1:0]                      exception_cause_o;
    logic [XLEN-1:0]                      exception_tval_o;

    modport master (
        output commit_ack_i, commit_fu_i, commit_op_i, commit_rd_i, commit_rs1_i,
               commit_result_i, commit_pc_i, commit_ex_valid_i,
        input  exception_valid_o, exception_cause_o, exception_tval_o
    );

    modport slave (
        input  commit_ack_i, commit_fu_i, commit_op_i, commit_rd_i, commit_rs1_i,
               commit_result_i, commit_pc_i, commit_ex_valid_i,
        output exception_valid_o, exception_cause_o, exception_tval_o
    );
endinterface

// File: rtl/commit_cfi_marker_checker.sv
// Commit-stage CFI checker: every committed call/ret must be immediately followed,
// in program order across all commit ports, by its marker NOP.

module commit_cfi_lane #(
    parameter logic [3:0] FU_CTRL_FLOW = 4'd4,
    parameter logic [7:0] OP_JAL       = 8'd20,
    parameter logic [7:0] OP_JALR      = 8'd19,
    parameter logic [7:0] NOP_OP       = 8'd0,
    parameter logic [4:0] NOP_RD       = 5'd0,
    parameter logic [4:0] NOP_RS1      = 5'd0,
    parameter logic [4:0] IMM_CALL     = 5'h2,
    parameter logic [4:0] IMM_RET      = 5'h1
) (
    input  logic [3:0] i_fu,
    input  logic [7:0] i_op,
    input  logic [5:0] i_rd,
    input  logic [5:0] i_rs1,
    input  logic [4:0] i_imm,
    output logic       o_call,
    output logic       o_ret,
    output logic       o_mark_call,
    output logic       o_mark_ret
);
    logic w_mark;

    assign o_call      = (i_fu == FU_CTRL_FLOW) && ((i_op == OP_JAL) || (i_op == OP_JALR))
                         && (i_rd != 6'd0);
    assign o_ret       = (i_op == OP_JALR) && (i_rd == 6'd0) && (i_rs1 == 6'd1);
    // Only the low five register bits take part in the marker match.
    assign w_mark      = (i_op == NOP_OP) && (i_rd[4:0] == NOP_RD) && (i_rs1[4:0] == NOP_RS1);
    assign o_mark_call = w_mark && (i_imm == IMM_CALL);
    assign o_mark_ret  = w_mark && (i_imm == IMM_RET);
endmodule

module commit_cfi_marker_checker #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = 64,
    parameter logic [7:0]  NOP_OP          = 8'd0,
    parameter logic [4:0]  NOP_RD          = 5'd0,
    parameter logic [4:0]  NOP_RS1         = 5'd0,
    parameter logic [4:0]  IMM_CALL        = 5'h2,
    parameter logic [4:0]  IMM_RET         = 5'h1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   en_i,
    input  logic                   count_only_i,
    commit_cfi_marker_checker_if.slave cif,
    output logic [1:0]             pending_o,
    output logic [CNT_WIDTH-1:0]   call_viol_cnt_o,
    output logic [CNT_WIDTH-1:0]   ret_viol_cnt_o
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_CALL = 2'd1;
    localparam logic [1:0] ST_WAIT_RET  = 2'd2;

    localparam logic [XLEN-1:0] CAUSE_BREAKPOINT = XLEN'(3);

    localparam int unsigned NW = $clog2(NR_COMMIT_PORTS + 1);
    localparam int unsigned SW = CNT_WIDTH + NW;
    localparam logic [NW-1:0] N_ONE = NW'(1);

    logic [NR_COMMIT_PORTS-1:0] w_call, w_ret, w_mark_call, w_mark_ret;

    logic [1:0]            r_pending;
    logic                  r_ex_valid;
    logic [XLEN-1:0]       r_ex_cause, r_ex_tval;
    logic [CNT_WIDTH-1:0]  r_call_cnt, r_ret_cnt;

    logic [1:0]            w_state;
    logic                  w_stop, w_hit, w_viol;
    logic [NW-1:0]         w_call_n, w_ret_n;
    logic [XLEN-1:0]       w_tval;
    logic                  w_active, w_report;
    logic [SW-1:0]         w_call_sum, w_ret_sum;
    logic [CNT_WIDTH-1:0]  w_call_next, w_ret_next;

    for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_lane
        commit_cfi_lane #(
            .NOP_OP  (NOP_OP),
            .NOP_RD  (NOP_RD),
            .NOP_RS1 (NOP_RS1),
            .IMM_CALL(IMM_CALL),
            .IMM_RET (IMM_RET)
        ) u_lane (
            .i_fu       (cif.commit_fu_i[g]),
            .i_op       (cif.commit_op_i[g]),
            .i_rd       (cif.commit_rd_i[g]),
            .i_rs1      (cif.commit_rs1_i[g]),
            .i_imm      (cif.commit_result_i[g][4:0]),
            .o_call     (w_call[g]),
            .o_ret      (w_ret[g]),
            .o_mark_call(w_mark_call[g]),
            .o_mark_ret (w_mark_ret[g])
        );
    end

    // In-order scan carrying a working copy of the obligation; stops at the first un-acked port.
    always_comb begin
        w_state  = r_pending;
        w_stop   = 1'b0;
        w_hit    = 1'b0;
        w_viol   = 1'b0;
        w_call_n = '0;
        w_ret_n  = '0;
        w_tval   = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (!w_stop) begin
                if (!cif.commit_ack_i[i]) begin
                    w_stop = 1'b1;
                end else if (cif.commit_ex_valid_i[i]) begin
                    w_state = ST_IDLE;
                end else begin
                    w_viol = ((w_state == ST_WAIT_CALL) && !w_mark_call[i]) ||
                             ((w_state == ST_WAIT_RET)  && !w_mark_ret[i]);
                    if (w_viol) begin
                        if (w_state == ST_WAIT_CALL) w_call_n = w_call_n + N_ONE;
                        else                         w_ret_n  = w_ret_n + N_ONE;
                        if (!w_hit) begin
                            w_hit  = 1'b1;
                            w_tval = cif.commit_pc_i[i];
                        end
                    end
                    // Re-arm even on the instruction that just violated.
                    w_state = w_call[i] ? ST_WAIT_CALL :
                              w_ret[i]  ? ST_WAIT_RET  : ST_IDLE;
                end
            end
        end
    end

    assign w_active   = en_i && !flush_i;
    assign w_report   = w_active && w_hit && !count_only_i;
    assign w_call_sum = SW'(r_call_cnt) + SW'(w_call_n);
    assign w_ret_sum  = SW'(r_ret_cnt) + SW'(w_ret_n);
    assign w_call_next = (w_call_sum[SW-1:CNT_WIDTH] != '0) ? '1 : w_call_sum[CNT_WIDTH-1:0];
    assign w_ret_next  = (w_ret_sum[SW-1:CNT_WIDTH]  != '0) ? '1 : w_ret_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pending  <= ST_IDLE;
            r_ex_valid <= 1'b0;
            r_ex_cause <= '0;
            r_ex_tval  <= '0;
            r_call_cnt <= '0;
            r_ret_cnt  <= '0;
        end else begin
            r_pending  <= w_active ? w_state : ST_IDLE;
            r_ex_valid <= w_report;
            r_ex_cause <= w_report ? CAUSE_BREAKPOINT : '0;
            r_ex_tval  <= w_report ? w_tval : '0;
            if (w_active) begin
                r_call_cnt <= w_call_next;
                r_ret_cnt  <= w_ret_next;
            end
        end
    end

    assign cif.exception_valid_o = r_ex_valid;
    assign cif.exception_cause_o = r_ex_cause;
    assign cif.exception_tval_o  = r_ex_tval;
    assign pending_o             = r_pending;
    assign call_viol_cnt_o       = r_call_cnt;
    assign ret_viol_cnt_o        = r_ret_cnt;
endmodule

// File: tb/tb_commit_cfi_marker_checker.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and
// compares one expectation per clock against the registered outputs.
module tb_commit_cfi_marker_checker;
    localparam int NR  = 4;
    localparam int CW  = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [7:0] OP_ADD = 8'd0, OP_JALR = 8'd19, OP_JAL = 8'd20;
    localparam logic [3:0] FU_ALU = 4'd3, FU_CF = 4'd4;
    localparam int K_CALL = 0, K_RET = 1, K_MCALL = 2, K_MRET = 3, K_OTHER = 4, K_NEAR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst_n, s_en, s_flush, s_co;
    logic [NR-1:0]           s_ack, s_exv;
    logic [NR-1:0][3:0]      s_fu;
    logic [NR-1:0][7:0]      s_op;
    logic [NR-1:0][5:0]      s_rd, s_rs1;
    logic [NR-1:0][63:0]     s_res, s_pc;

    logic [1:0]    pending;
    logic [CW-1:0] call_cnt, ret_cnt;

    commit_cfi_marker_checker_if #(.NR_COMMIT_PORTS(NR), .XLEN(64)) cif ();
    assign cif.commit_ack_i      = s_ack;
    assign cif.commit_fu_i       = s_fu;
    assign cif.commit_op_i       = s_op;
    assign cif.commit_rd_i       = s_rd;
    assign cif.commit_rs1_i      = s_rs1;
    assign cif.commit_result_i   = s_res;
    assign cif.commit_pc_i       = s_pc;
    assign cif.commit_ex_valid_i = s_exv;

    commit_cfi_marker_checker #(.NR_COMMIT_PORTS(NR), .XLEN(64), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(s_rst_n), .flush_i(s_flush), .en_i(s_en),
        .count_only_i(s_co), .cif(cif), .pending_o(pending),
        .call_viol_cnt_o(call_cnt), .ret_viol_cnt_o(ret_cnt)
    );

    typedef struct {
        bit          exv;
        logic [63:0] cause, tval;
        int          pend, ccnt, rcnt;
        string       tag;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0, n_mis = 0;
    int m_need = 0, m_call = 0, m_ret = 0; // obligation: 0 none, 1 call marker, 2 ret marker
    string cur_tag = "reset";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: outputs are registered, so one expectation is due 1 time unit after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk({e.tag, ".ex_valid"}, 64'(cif.exception_valid_o), 64'(e.exv));
                chk({e.tag, ".cause"},    cif.exception_cause_o,      e.cause);
                chk({e.tag, ".tval"},     cif.exception_tval_o,       e.tval);
                chk({e.tag, ".pending"},  64'(pending),               64'(e.pend));
                chk({e.tag, ".call_cnt"}, 64'(call_cnt),              64'(e.ccnt));
                chk({e.tag, ".ret_cnt"},  64'(ret_cnt),               64'(e.rcnt));
            end
        end
    end

    function automatic bit is_call(int p);
        return s_fu[p] == FU_CF && (s_op[p] == OP_JAL || s_op[p] == OP_JALR) && s_rd[p] != 0;
    endfunction
    function automatic bit is_ret(int p);
        return s_op[p] == OP_JALR && s_rd[p] == 0 && s_rs1[p] == 1;
    endfunction
    function automatic bit is_mark(int p, int k);
        return s_op[p] == OP_ADD && s_rd[p][4:0] == 0 && s_rs1[p][4:0] == 0 && s_res[p][4:0] == 5'(k);
    endfunction

    // Reference: the committed stream is the acked prefix; each call/ret obliges the next
    // non-excepting instruction in that stream to be the matching marker.
    task automatic issue();
        exp_t e;
        int stream[$];
        int cv = 0, rv = 0;
        bit hit = 0;
        logic [63:0] tv = '0;
        if (!s_rst_n) begin
            m_need = 0; m_call = 0; m_ret = 0;
        end else if (s_en && !s_flush) begin
            for (int i = 0; i < NR && s_ack[i]; i++) stream.push_back(i);
            foreach (stream[j]) begin
                int p = stream[j];
                if (s_exv[p]) begin m_need = 0; continue; end
                if ((m_need == 1 && !is_mark(p, 2)) || (m_need == 2 && !is_mark(p, 1))) begin
                    if (m_need == 1) cv++; else rv++;
                    if (!hit) begin hit = 1; tv = s_pc[p]; end
                end
                m_need = is_call(p) ? 1 : is_ret(p) ? 2 : 0;
            end
            m_call = (m_call + cv > CMAX) ? CMAX : m_call + cv;
            m_ret  = (m_ret + rv > CMAX) ? CMAX : m_ret + rv;
        end else begin
            m_need = 0;
        end
        e.exv   = hit && !s_co;
        e.cause = e.exv ? 64'd3 : 64'd0;
        e.tval  = e.exv ? tv : 64'd0;
        e.pend  = m_need;
        e.ccnt  = m_call;
        e.rcnt  = m_ret;
        e.tag   = cur_tag;
        expq.push_back(e);
    endtask

    task automatic clear();
        s_rst_n = 1; s_en = 1; s_flush = 0; s_co = 0;
        s_ack = '0; s_exv = '0; s_fu = '0; s_op = '0; s_rd = '0; s_rs1 = '0;
        s_res = '0; s_pc = '0;
    endtask

    task automatic set_p(int i, int kind, logic [63:0] pc);
        s_pc[i] = pc;
        s_rs1[i] = 6'($urandom_range(0, 63));
        s_res[i] = {$urandom, $urandom};
        case (kind)
            K_CALL: begin
                s_fu[i] = FU_CF; s_op[i] = ($urandom_range(0, 1) != 0) ? OP_JAL : OP_JALR;
                s_rd[i] = 6'($urandom_range(1, 63));
            end
            K_RET: begin s_fu[i] = FU_CF; s_op[i] = OP_JALR; s_rd[i] = 0; s_rs1[i] = 1; end
            K_MCALL, K_MRET: begin
                s_fu[i] = FU_ALU; s_op[i] = OP_ADD;
                s_rd[i] = ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h00;
                s_rs1[i] = ($urandom_range(0, 1) != 0) ? 6'h20 : 6'h00;
                s_res[i][4:0] = (kind == K_MCALL) ? 5'h2 : 5'h1;
            end
            K_NEAR: begin
                s_fu[i] = FU_ALU; s_op[i] = OP_ADD; s_rd[i] = 0; s_rs1[i] = 0;
                s_res[i][4:0] = 5'($urandom_range(1, 2));
                case ($urandom_range(0, 3))
                    0: s_rd[i] = 6'($urandom_range(1, 31));
                    1: s_rs1[i] = 6'($urandom_range(1, 31));
                    2: s_op[i] = 8'd5;
                    default: s_res[i][4:0] = 5'($urandom_range(3, 31));
                endcase
            end
            default: begin
                s_fu[i] = 4'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: s_op[i] = OP_ADD;
                    1: s_op[i] = OP_JALR;
                    2: s_op[i] = OP_JAL;
                    default: s_op[i] = 8'($urandom_range(1, 40));
                endcase
                s_rd[i] = 6'($urandom_range(0, 63));
            end
        endcase
    endtask

    task automatic cyc(input string tag);
        cur_tag = tag;
        issue();
        @(negedge clk);
        clear();
    endtask

    initial begin
        clear();
        s_rst_n = 0;
        @(negedge clk);
        clear(); s_rst_n = 0; cyc("reset");
        clear(); cyc("idle");

        // call + marker in the same cycle
        s_ack = 4'b0011; set_p(0, K_CALL, 64'h8000_0000); set_p(1, K_MCALL, 64'h8000_0004);
        cyc("call_mark_same"); cyc("call_mark_after");

        // ret on port1, wrong marker on port0 next cycle
        s_ack = 4'b0011; set_p(0, K_OTHER, 64'hfc); set_p(1, K_RET, 64'h100);
        s_op[0] = 8'd5; cyc("ret_t");
        s_ack = 4'b0001; set_p(0, K_MCALL, 64'h104); cyc("ret_bad_mark");
        cyc("ret_bad_after");

        // ret on last port, correct marker on port0 next cycle
        s_ack = 4'b1111; for (int i = 0; i < 3; i++) begin set_p(i, K_OTHER, 64'h200 + 64'(4*i)); s_op[i] = 8'd5; end
        set_p(3, K_RET, 64'h20c); cyc("ret_last");
        s_ack = 4'b0001; set_p(0, K_MRET, 64'h210); cyc("ret_mark_next"); cyc("ret_mark_after");

        // four-port chain: call, non-marker, ret, non-marker
        s_ack = 4'b1111; set_p(0, K_CALL, 64'h300); set_p(1, K_OTHER, 64'h304); s_op[1] = 8'd5;
        set_p(2, K_RET, 64'h308); set_p(3, K_OTHER, 64'h30c); s_op[3] = 8'd5;
        cyc("chain4"); cyc("chain4_after");

        // back-to-back violations
        for (int k = 0; k < 2; k++) begin
            s_ack = 4'b0011; set_p(0, K_CALL, 64'h400 + 64'(16*k)); set_p(1, K_NEAR, 64'h404 + 64'(16*k));
            cyc("b2b");
        end
        cyc("b2b_after");

        // ack gap hides port3; then call on last port, flush in marker cycle
        s_ack = 4'b1011; set_p(0, K_OTHER, 64'h500); s_op[0] = 8'd5; set_p(1, K_OTHER, 64'h504); s_op[1] = 8'd5;
        set_p(2, K_CALL, 64'h508); set_p(3, K_NEAR, 64'h50c); cyc("ack_gap");
        s_ack = 4'b1111; for (int i = 0; i < 3; i++) begin set_p(i, K_OTHER, 64'h600 + 64'(4*i)); s_op[i] = 8'd5; end
        set_p(3, K_CALL, 64'h60c); cyc("call_last");
        s_flush = 1; s_ack = 4'b0001; set_p(0, K_NEAR, 64'h610); cyc("flush"); cyc("flush_after");

        // count-only saturation
        for (int k = 0; k < 9; k++) begin
            s_co = 1; s_ack = 4'b0011; set_p(0, K_RET, 64'h700 + 64'(8*k)); set_p(1, K_NEAR, 64'h704 + 64'(8*k));
            cyc("count_only");
        end

        // disabled: call then bad marker change nothing
        s_en = 0; s_ack = 4'b0001; set_p(0, K_CALL, 64'h800); cyc("dis_call");
        s_en = 0; s_ack = 4'b0001; set_p(0, K_NEAR, 64'h804); cyc("dis_mark");

        // reset while waiting for a call marker
        s_ack = 4'b0001; set_p(0, K_CALL, 64'h900); cyc("wait_call");
        s_rst_n = 0; s_ack = 4'b0001; set_p(0, K_NEAR, 64'h904); cyc("rst_mid");
        s_ack = 4'b0001; set_p(0, K_NEAR, 64'h908); cyc("rst_after");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s_rst_n = ($urandom_range(0, 199) != 0);
            s_en    = ($urandom_range(0, 9) != 0);
            s_flush = ($urandom_range(0, 19) == 0);
            s_co    = ($urandom_range(0, 9) == 0);
            s_ack   = ($urandom_range(0, 3) == 0) ? NR'($urandom) : NR'((1 << $urandom_range(0, NR)) - 1);
            for (int i = 0; i < NR; i++) begin
                set_p(i, $urandom_range(0, 5), {32'h0, $urandom} & ~64'h3);
                s_exv[i] = ($urandom_range(0, 11) == 0);
            end
            cyc("rand");
        end

        for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
        if (expq.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
